ps2_note_decoder: RTL and testbench
===================================

Name: ps2_note_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver (KeyboardWrapper).
- Consumes its 8-bit scan-code bytes (set 2) and Valid strobe.
- Tracks break (F0) and extended (E0) prefixes, maps a 12-key piano row to note numbers with an octave register, and suppresses typematic repeats.
- Emits one-cycle note on/off events and an Enter command pulse for the player/recorder logic.

Parameters:
- TIMEOUT_CYCLES, 2000000, clocks a prefix state may wait for its follow-up byte before abandoning it (20 ms at 100 MHz).
- OCTAVE_RESET, 4, octave value loaded at reset (0..7).

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ScanData  input  8  scan-code byte from the keyboard receiver.
- Valid  input  1  byte-ready from the receiver. May stay high for more than one cycle. Only its rising edge is used.
- NoteValid  output  1  one-cycle pulse, note event present.
- NoteOn  output  1  1 = key press, 0 = key release. Meaningful only while NoteValid = 1.
- NoteIndex  output  7  Octave*12 + note, range 0..95.
- KeysHeld  output  12  bit n = piano note n currently held.
- Octave  output  3  current octave.
- EnterPulse  output  1  one-cycle pulse on Enter (0x5A) make.

Behaviour:
- Reset (synchronous): all outputs and state return to these values.
  - NoteValid = 0, NoteOn = 0, NoteIndex = 0, KeysHeld = 0, EnterPulse = 0.
  - Octave = OCTAVE_RESET, FSM = IDLE, timeout counter = 0, Valid-edge register = 0.
  - Reset mid-prefix discards the prefix.
- Byte acceptance: a byte is accepted in cycle N when Valid = 1 at N and was 0 at N-1. ScanData is sampled in that same cycle.
- Latency: all outputs are registered. NoteValid, EnterPulse, KeysHeld and Octave updates appear in cycle N+1. Pulses last exactly one cycle.
- Note map (make code -> note):
  - 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5
  - 2C->6, 34->7, 35->8, 33->9, 3C->10, 3B->11
  - Control keys: 1A (Z) = octave down, 22 (X) = octave up, 5A = Enter.
  - All other codes are unmapped and ignored.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK.
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is processed as a make, stay IDLE.
  - BREAK: next byte is processed as a break -> IDLE.
  - EXT: F0 -> EXT_BREAK; any other byte is discarded (extended keys ignored) -> IDLE.
  - EXT_BREAK: any byte is discarded -> IDLE.
  - F0 or E0 arriving in BREAK or EXT_BREAK is treated as a data byte (discarded) -> IDLE.
- Timeout: the counter runs in any non-IDLE state and clears on every accepted byte and on entry to IDLE. When it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE, with no output.
- Make of mapped note n:
  - If KeysHeld[n] = 0: set KeysHeld[n], NoteValid = 1, NoteOn = 1, NoteIndex = Octave*12+n.
  - If already held: no event (typematic suppression).
- Break of mapped note n:
  - If held: clear the bit, NoteValid = 1, NoteOn = 0, NoteIndex = Octave*12+n.
  - If not held: no event.
- Octave keys:
  - Act on make only, and only when KeysHeld == 0. Otherwise the key is ignored.
  - Saturate at 0 and 7; no wrap.
  - Break of an octave key has no effect.
- Enter: make -> EnterPulse = 1. Break produces no output.
- Arithmetic: NoteIndex = {Octave,3'b0}... computed as Octave*12+n in 7 bits; the maximum, 95, fits.
- Simultaneous events: only one byte can be accepted per cycle, so at most one of NoteValid or EnterPulse fires per cycle.
- Reset has priority over a concurrent Valid edge; that byte is lost.

Test Plan:
1. Reset -> all outputs 0, Octave = 4, KeysHeld = 000.
2. Note press and release:
   - Send 1C -> NoteValid pulse, NoteOn = 1, NoteIndex = 48, KeysHeld = 001.
   - Send 1C again -> no pulse.
   - Send F0, 1C -> NoteOn = 0, NoteIndex = 48, KeysHeld = 000.
   - Hold Valid high 5 cycles -> exactly one event.
3. Enter and unmapped codes:
   - Send 5A -> single EnterPulse, no NoteValid.
   - Send F0, 5A, F0, 15 -> no pulses, FSM ends in IDLE.
   - Then 1D -> make, NoteIndex = 49.
4. Octave control:
   - Send 22 four times -> Octave = 7 (saturated). Send 3B -> NoteIndex = 95.
   - Send 1A while 3B held -> Octave stays 7.
   - Release 3B; send 1A eight times -> Octave = 0. Send 1C -> NoteIndex = 0.
5. Extended codes:
   - Send E0, 1C -> no event, KeysHeld unchanged.
   - Send E0, F0, 1C after pressing 1C -> no release event, bit 0 stays set.
6. Timeout and reset mid-prefix:
   - Send F0, wait TIMEOUT_CYCLES -> FSM in IDLE. Next 1C -> make event (NoteOn = 1).
   - Send F0, assert Reset one cycle, send 1C -> make event, Octave = 4.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code to piano note decoder: tracks break/extended prefixes,
// maps a 12-key row to note numbers with an octave register, suppresses repeats.
module ps2_note_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [2:0]  OCTAVE_RESET   = 3'd4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  ScanData,
  input  logic        Valid,
  output logic        NoteValid,
  output logic        NoteOn,
  output logic [6:0]  NoteIndex,
  output logic [11:0] KeysHeld,
  output logic [2:0]  Octave,
  output logic        EnterPulse,
  output logic [1:0]  fsm_state
);

  // Input contract: a byte is taken on the rising edge of Valid only; there is
  // no back-pressure, so Valid may stay high as long as the receiver likes.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] timer;
  logic          valid_q;
  logic          accept;
  logic          note_hit;
  logic [3:0]    note_num;
  logic [6:0]    note_idx;

  assign accept    = Valid & ~valid_q;
  assign fsm_state = state;

  always_comb begin
    note_hit = 1'b1;
    note_num = 4'd0;
    case (ScanData)
      8'h1C:   note_num = 4'd0;
      8'h1D:   note_num = 4'd1;
      8'h1B:   note_num = 4'd2;
      8'h24:   note_num = 4'd3;
      8'h23:   note_num = 4'd4;
      8'h2B:   note_num = 4'd5;
      8'h2C:   note_num = 4'd6;
      8'h34:   note_num = 4'd7;
      8'h35:   note_num = 4'd8;
      8'h33:   note_num = 4'd9;
      8'h3C:   note_num = 4'd10;
      8'h3B:   note_num = 4'd11;
      default: note_hit = 1'b0;
    endcase
  end

  // Octave*12 as Octave*8 + Octave*4; the largest result (7*12+11 = 95) fits 7 bits.
  assign note_idx = {1'b0, Octave, 3'b000} + {2'b00, Octave, 2'b00} + {3'b000, note_num};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      timer      <= '0;
      valid_q    <= 1'b0;
      NoteValid  <= 1'b0;
      NoteOn     <= 1'b0;
      NoteIndex  <= 7'd0;
      KeysHeld   <= 12'd0;
      Octave     <= OCTAVE_RESET;
      EnterPulse <= 1'b0;
    end else begin
      valid_q    <= Valid;
      NoteValid  <= 1'b0;
      EnterPulse <= 1'b0;
      if (accept) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (ScanData == 8'hF0) begin
              state <= BREAK;
            end else if (ScanData == 8'hE0) begin
              state <= EXT;
            end else if (note_hit) begin
              // Typematic repeats of a held key produce no event.
              if (!KeysHeld[note_num]) begin
                KeysHeld[note_num] <= 1'b1;
                NoteValid          <= 1'b1;
                NoteOn             <= 1'b1;
                NoteIndex          <= note_idx;
              end
            end else if (ScanData == 8'h5A) begin
              EnterPulse <= 1'b1;
            end else if (ScanData == 8'h1A) begin
              if (KeysHeld == 12'd0 && Octave != 3'd0) Octave <= Octave - 3'd1;
            end else if (ScanData == 8'h22) begin
              if (KeysHeld == 12'd0 && Octave != 3'd7) Octave <= Octave + 3'd1;
            end
          end
          BREAK: begin
            state <= IDLE;
            if (note_hit && KeysHeld[note_num]) begin
              KeysHeld[note_num] <= 1'b0;
              NoteValid          <= 1'b1;
              NoteOn             <= 1'b0;
              NoteIndex          <= note_idx;
            end
          end
          EXT:     state <= (ScanData == 8'hF0) ? EXT_BREAK : IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Abandon a prefix whose follow-up byte never arrives.
        if (timer == TIMER_LAST) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          timer <= timer + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: expected note/enter events are queued by
// the driver and popped by an independent monitor whenever the DUT pulses.
module tb_ps2_note_decoder;

  localparam int TIMEOUT = 40;
  localparam logic [8:0] ENTER_EV = 9'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  scan_data;
  logic        valid;
  logic        note_valid;
  logic        note_on;
  logic [6:0]  note_index;
  logic [11:0] keys_held;
  logic [2:0]  octave;
  logic        enter_pulse;
  logic [1:0]  fsm_state;

  logic [8:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_note_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .OCTAVE_RESET  (3'd4)
  ) dut (
    .Clock     (clk),
    .Reset     (reset),
    .ScanData  (scan_data),
    .Valid     (valid),
    .NoteValid (note_valid),
    .NoteOn    (note_on),
    .NoteIndex (note_index),
    .KeysHeld  (keys_held),
    .Octave    (octave),
    .EnterPulse(enter_pulse),
    .fsm_state (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [8:0] got;
    if (note_valid || enter_pulse) begin
      got = {enter_pulse, note_valid ? note_on : 1'b0, note_valid ? note_index : 7'd0};
      check("single_pulse", {31'd0, note_valid & enter_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", got);
      end else begin
        check("event", {23'd0, got}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b, input int hold = 1);
    @(negedge clk);
    scan_data = b;
    valid     = 1'b1;
    repeat (hold) @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic make_ev(input logic [7:0] code, input logic [6:0] idx);
    exp_q.push_back({1'b0, 1'b1, idx});
    send(code);
  endtask

  task automatic break_ev(input logic [7:0] code, input logic [6:0] idx);
    send(8'hF0);
    exp_q.push_back({1'b0, 1'b0, idx});
    send(code);
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; scan_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_note_valid", {31'd0, note_valid}, 32'd0);
    check("rst_note_on", {31'd0, note_on}, 32'd0);
    check("rst_note_index", {25'd0, note_index}, 32'd0);
    check("rst_keys", {20'd0, keys_held}, 32'd0);
    check("rst_octave", {29'd0, octave}, 32'd4);
    check("rst_enter", {31'd0, enter_pulse}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);

    // Press, repeat, release, long Valid
    make_ev(8'h1C, 7'd48);
    check("keys_1c", {20'd0, keys_held}, 32'h001);
    send(8'h1C);
    drained("typematic");
    break_ev(8'h1C, 7'd48);
    check("keys_rel", {20'd0, keys_held}, 32'h000);
    exp_q.push_back({1'b0, 1'b1, 7'd48});
    send(8'h1C, 5);
    drained("long_valid");
    break_ev(8'h1C, 7'd48);

    // Enter and unmapped codes
    exp_q.push_back(ENTER_EV);
    send(8'h5A);
    send(8'hF0); send(8'h5A); send(8'hF0); send(8'h15);
    drained("enter_unmapped");
    check("state_idle_1", {30'd0, fsm_state}, 32'd0);
    make_ev(8'h1D, 7'd49);
    check("keys_1d", {20'd0, keys_held}, 32'h002);
    break_ev(8'h1D, 7'd49);

    // Octave control
    repeat (4) send(8'h22);
    check("oct_sat_hi", {29'd0, octave}, 32'd7);
    make_ev(8'h3B, 7'd95);
    send(8'h1A);
    check("oct_locked", {29'd0, octave}, 32'd7);
    break_ev(8'h3B, 7'd95);
    send(8'h1A);
    check("oct_down_1", {29'd0, octave}, 32'd6);
    repeat (7) send(8'h1A);
    check("oct_sat_lo", {29'd0, octave}, 32'd0);
    make_ev(8'h1C, 7'd0);
    drained("octave");

    // Extended codes are ignored
    send(8'hE0); send(8'h1C);
    check("ext_keys", {20'd0, keys_held}, 32'h001);
    send(8'hE0); send(8'hF0); send(8'h1C);
    check("ext_brk_keys", {20'd0, keys_held}, 32'h001);
    check("state_idle_2", {30'd0, fsm_state}, 32'd0);
    drained("extended");
    break_ev(8'h1C, 7'd0);

    // Prefix timeout
    send(8'hF0);
    repeat (TIMEOUT - 6) @(negedge clk);
    check("to_pending", {30'd0, fsm_state}, 32'd1);
    repeat (10) @(negedge clk);
    check("to_idle", {30'd0, fsm_state}, 32'd0);
    make_ev(8'h1C, 7'd0);
    drained("timeout");

    // Reset mid-prefix
    send(8'hF0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_rst_state", {30'd0, fsm_state}, 32'd0);
    check("mid_rst_octave", {29'd0, octave}, 32'd4);
    check("mid_rst_keys", {20'd0, keys_held}, 32'd0);
    make_ev(8'h1C, 7'd48);
    check("mid_rst_make", {20'd0, keys_held}, 32'h001);
    repeat (3) @(negedge clk);
    drained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
